// File: rtl/fp_pkg.sv
// Issue-controller types: extension selector, FSM states and rounding-mode legality.
package fp_pkg;

    localparam int unsigned FLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        RV32FNone,
        RV32FSingle,
        RV64FDouble
    } rvf_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } issue_state_e;

    localparam logic [2:0] RM_RSVD_5 = 3'b101;
    localparam logic [2:0] RM_RSVD_6 = 3'b110;
    localparam logic [2:0] RM_DYN    = 3'b111;

    // A resolved mode of DYN means frm itself held DYN, which is just as illegal.
    function automatic logic rm_is_invalid(input logic [2:0] rm);
        return (rm == RM_RSVD_5) || (rm == RM_RSVD_6) || (rm == RM_DYN);
    endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// Operator, format and rounding-mode encodings shared with the FPU datapath.
// Values follow the FPnew core so requests pass straight through.
package fpnew_pkg;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Request/response channel between the issue controller (master) and the FPU (slave).
interface fp_issue_ctrl_if #(
    parameter int unsigned FLEN = fp_pkg::FLEN_DEFAULT
);

    logic                    in_valid;
    logic                    in_ready;
    fpnew_pkg::operation_e   op;
    logic                    op_mod;
    fpnew_pkg::fp_format_e   src_fmt;
    fpnew_pkg::fp_format_e   dst_fmt;
    fpnew_pkg::roundmode_e   rnd;
    logic [3*FLEN-1:0]       operands;
    logic                    out_valid;
    logic                    out_ready;
    logic [FLEN-1:0]         result;
    logic [4:0]              status;
    logic                    flush;

    modport master (
        output in_valid, op, op_mod, src_fmt, dst_fmt, rnd, operands, out_ready, flush,
        input  in_ready, out_valid, result, status
    );

    modport slave (
        input  in_valid, op, op_mod, src_fmt, dst_fmt, rnd, operands, out_ready, flush,
        output in_ready, out_valid, result, status
    );

endinterface

// File: rtl/fp_wb_fmt.sv
// Shapes an FPU result for the register file: integer results are sign-extended
// from bit 31 and single-precision FP results are NaN-boxed when FLEN is 64.
module fp_wb_fmt
    import fpnew_pkg::*;
#(
    parameter int unsigned FLEN = 64
) (
    input  logic [FLEN-1:0] result_i,
    input  fp_format_e      dst_fmt_i,
    input  logic            fp_we_i,
    input  logic            int_we_i,
    output logic [FLEN-1:0] wdata_o
);

    generate
        if (FLEN == 64) begin : g_flen64
            always_comb begin
                wdata_o = result_i;
                if (int_we_i) begin
                    wdata_o = {{32{result_i[31]}}, result_i[31:0]};
                end else if (fp_we_i && (dst_fmt_i == FP32)) begin
                    wdata_o = {32'hFFFF_FFFF, result_i[31:0]};
                end
            end
        end else begin : g_flen32
            logic unused_fmt;
            assign unused_fmt = ^{dst_fmt_i, fp_we_i, int_we_i};
            assign wdata_o    = result_i;
        end
    endgenerate

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issues one decoded FP operation at a time to the FPU, waits for its result and
// writes it back to the FP or integer register file, accumulating sticky flags.
module fp_issue_ctrl
    import fpnew_pkg::*;
    import fp_pkg::*;
#(
    parameter int unsigned FLEN = FLEN_DEFAULT,
    parameter rvf_e        RVF  = RV64FDouble
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  dec_valid_i,
    output logic                  dec_ready_o,
    input  operation_e            dec_op_i,
    input  logic                  dec_op_mod_i,
    input  fp_format_e            dec_src_fmt_i,
    input  fp_format_e            dec_dst_fmt_i,
    input  logic [2:0]            dec_rm_i,
    input  logic [4:0]            dec_rd_i,
    input  logic                  dec_fp_we_i,
    input  logic                  dec_int_we_i,

    input  logic [FLEN-1:0]       op_a_i,
    input  logic [FLEN-1:0]       op_b_i,
    input  logic [FLEN-1:0]       op_c_i,
    input  logic [2:0]            frm_i,
    input  logic                  flush_i,
    input  logic                  fflags_clr_i,

    fp_issue_ctrl_if.master       fpu,

    output logic                  fp_rf_we_o,
    output logic                  int_rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [FLEN-1:0]       rf_wdata_o,
    output logic [4:0]            fflags_o,
    output logic                  illegal_rm_o,
    output logic                  busy_o
);

    issue_state_e       state_q;
    operation_e         op_q;
    logic               op_mod_q;
    fp_format_e         src_fmt_q;
    fp_format_e         dst_fmt_q;
    roundmode_e         rnd_q;
    logic [3*FLEN-1:0]  operands_q;
    logic [4:0]         rd_q;
    logic               fp_we_q;
    logic               int_we_q;
    logic [FLEN-1:0]    wdata_q;
    logic [4:0]         fflags_q;
    logic               illegal_q;
    logic               flush_q;

    logic [2:0]         rm_resolved;
    logic               rm_illegal;
    logic [FLEN-1:0]    wb_data;

    assign rm_resolved = (dec_rm_i != RM_DYN) ? dec_rm_i : frm_i;
    assign rm_illegal  = rm_is_invalid(rm_resolved) || (RVF == RV32FNone);

    fp_wb_fmt #(.FLEN(FLEN)) u_wb_fmt (
        .result_i  (fpu.result),
        .dst_fmt_i (dst_fmt_q),
        .fp_we_i   (fp_we_q),
        .int_we_i  (int_we_q),
        .wdata_o   (wb_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= FMADD;
            op_mod_q   <= 1'b0;
            src_fmt_q  <= FP32;
            dst_fmt_q  <= FP32;
            rnd_q      <= RNE;
            operands_q <= '0;
            rd_q       <= '0;
            fp_we_q    <= 1'b0;
            int_we_q   <= 1'b0;
            wdata_q    <= '0;
            fflags_q   <= '0;
            illegal_q  <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            flush_q   <= 1'b0;
            if (fflags_clr_i) begin
                fflags_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (dec_valid_i) begin
                        if (rm_illegal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            op_q       <= dec_op_i;
                            op_mod_q   <= dec_op_mod_i;
                            src_fmt_q  <= dec_src_fmt_i;
                            dst_fmt_q  <= dec_dst_fmt_i;
                            rnd_q      <= roundmode_e'(rm_resolved);
                            operands_q <= {op_c_i, op_b_i, op_a_i};
                            rd_q       <= dec_rd_i;
                            fp_we_q    <= dec_fp_we_i;
                            int_we_q   <= dec_int_we_i;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush_i) begin
                        flush_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (fpu.in_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A flush wins over a result arriving in the same cycle.
                    if (flush_i) begin
                        flush_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (fpu.out_valid) begin
                        wdata_q  <= wb_data;
                        fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | fpu.status;
                        state_q  <= WB;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign dec_ready_o   = (state_q == IDLE) && !rst_i;
    assign busy_o        = (state_q != IDLE);
    assign fp_rf_we_o    = (state_q == WB) && fp_we_q;
    assign int_rf_we_o   = (state_q == WB) && int_we_q;
    assign rf_waddr_o    = rd_q;
    assign rf_wdata_o    = wdata_q;
    assign fflags_o      = fflags_q;
    assign illegal_rm_o  = illegal_q;

    assign fpu.in_valid  = (state_q == ISSUE);
    assign fpu.out_ready = (state_q == WAIT);
    assign fpu.flush     = flush_q;
    assign fpu.op        = op_q;
    assign fpu.op_mod    = op_mod_q;
    assign fpu.src_fmt   = src_fmt_q;
    assign fpu.dst_fmt   = dst_fmt_q;
    assign fpu.rnd       = rnd_q;
    assign fpu.operands  = operands_q;

endmodule
